nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder.sv | 106 ++++++++++
 tb/tb_nibble_serial_adder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract through one 4-bit ripple slice.
// Ports: clk_i/rst_n_i, start/sub/ci/a/b in; busy/done, s/co/ov/z out.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic             ci_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             co_o,
  output logic             ov_o,
  output logic             z_o
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       sum;
  logic             c_out;
  logic             c_msb;
  logic             accept;
  logic             last;

  assign accept = start_i &&
                  (state_q == IDLE || state_q == DONE);
  assign last   = (cnt_q == CW'(N - 1));
  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);

  always_comb begin
    a_nib = a_q[4*cnt_q +: 4];
    b_nib = b_q[4*cnt_q +: 4];
    {c_out, sum} = {1'b0, a_nib} + {1'b0, b_nib}
                 + {4'b0, carry_q};
    // carry into the nibble's top bit, recovered from its sum bit
    c_msb = a_nib[3] ^ b_nib[3] ^ sum[3];
    work_d = work_q;
    work_d[4*cnt_q +: 4] = sum;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = start_i ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_o     <= '0;
      co_o    <= 1'b0;
      ov_o    <= 1'b0;
      z_o     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= a_i;
        b_q     <= sub_i ? ~b_i : b_i;
        carry_q <= ci_i;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        work_q  <= work_d;
        carry_q <= c_out;
        cnt_q   <= last ? '0 : cnt_q + 1'b1;
        if (last) begin
          s_o  <= work_d;
          co_o <= c_out;
          ov_o <= c_msb ^ c_out;
          z_o  <= (work_d == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder.
// Covers WIDTH=16 and WIDTH=4 instances on one clock.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic        ci;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] s;
  logic        co;
  logic        ov;
  logic        z;

  logic        start4;
  logic        sub4;
  logic        ci4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        busy4;
  logic        done4;
  logic [3:0]  s4;
  logic        co4;
  logic        ov4;
  logic        z4;

  int n_chk = 0;
  int n_pass = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .start_i(start),
    .sub_i  (sub),
    .ci_i   (ci),
    .a_i    (a),
    .b_i    (b),
    .busy_o (busy),
    .done_o (done),
    .s_o    (s),
    .co_o   (co),
    .ov_o   (ov),
    .z_o    (z)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .start_i(start4),
    .sub_i  (sub4),
    .ci_i   (ci4),
    .a_i    (a4),
    .b_i    (b4),
    .busy_o (busy4),
    .done_o (done4),
    .s_o    (s4),
    .co_o   (co4),
    .ov_o   (ov4),
    .z_o    (z4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic op16(input logic sb, input logic cin,
                      input logic [15:0] av,
                      input logic [15:0] bv,
                      input logic [15:0] se,
                      input logic ce, input logic oe,
                      input logic ze);
    int n;
    @(negedge clk);
    start = 1'b1; sub = sb; ci = cin; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_on", busy, 1);
    chk("done_early", done, 0);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 4);
    chk("busy_in_done", busy, 0);
    chk("s", s, se);
    chk("co", co, ce);
    chk("ov", ov, oe);
    chk("z", z, ze);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
  endtask

  task automatic op4(input logic sb, input logic cin,
                     input logic [3:0] av,
                     input logic [3:0] bv,
                     input logic [3:0] se,
                     input logic ce, input logic oe,
                     input logic ze);
    int n;
    @(negedge clk);
    start4 = 1'b1; sub4 = sb; ci4 = cin;
    a4 = av; b4 = bv;
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("w4_busy_on", busy4, 1);
    n = 0;
    while (done4 !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w4_latency", n, 1);
    chk("w4_s", s4, se);
    chk("w4_co", co4, ce);
    chk("w4_ov", ov4, oe);
    chk("w4_z", z4, ze);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0; sub = 1'b0; ci = 1'b0;
    a = '0; b = '0;
    start4 = 1'b0; sub4 = 1'b0; ci4 = 1'b0;
    a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s", s, 0);
    chk("rst_flags", {co, ov, z}, 0);
    chk("rst_w4", {busy4, done4, s4, co4, ov4, z4}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    op16(0, 0, 16'h1234, 16'h0FFF, 16'h2233, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_s", s, 16'h2233);
    chk("idle_busy", busy, 0);
    op16(0, 0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1);
    op16(0, 0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0);
    op16(1, 1, 16'h8000, 16'h0001, 16'h7FFF, 1, 1, 0);
    op16(1, 1, 16'h0003, 16'h0005, 16'hFFFE, 0, 0, 0);
    op16(0, 1, 16'h00FF, 16'h0000, 16'h0100, 0, 0, 0);
    op16(1, 1, 16'h5A5A, 16'h5A5A, 16'h0000, 1, 0, 1);

    // start held high: back-to-back operations
    @(negedge clk);
    start = 1'b1; sub = 1'b0; ci = 1'b0;
    a = 16'h0001; b = 16'h0001;
    @(posedge clk); #1;
    a = 16'h1111;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hs_lat", n, 4);
    chk("hs_s1", s, 16'h0002);
    @(posedge clk); #1;
    chk("b2b_busy", busy, 1);
    chk("b2b_done", done, 0);
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("period", n, 5);
    chk("hs_s2", s, 16'h1112);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy2", busy, 1);
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("period2", n, 5);
    @(posedge clk); #1;

    // reset during the second busy cycle
    @(negedge clk);
    start = 1'b1; a = 16'h4321; b = 16'h1111;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_s", s, 0);
    chk("mr_flags", {co, ov, z}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) n++;
    end
    chk("no_done", n, 0);
    op16(0, 0, 16'h4321, 16'h1111, 16'h5432, 0, 0, 0);

    op4(0, 0, 4'h7, 4'h1, 4'h8, 0, 1, 0);
    op4(0, 0, 4'hF, 4'h1, 4'h0, 1, 0, 1);
    op4(1, 1, 4'h3, 4'h5, 4'hE, 0, 0, 0);
    op4(1, 1, 4'h8, 4'h1, 4'h7, 1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
